// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared constants and helpers for ctrl_pipe_chain
//
// Purpose: default bubble fill value and the saturating counter increment
// used by the control pipeline chain and its stages.
package ctrl_pipe_pkg;

   // Every bit of the default bubble bundle; a bubble is an all-zero control word.
   localparam logic BUBBLE_BIT_DEFAULT = 1'b0;

   // Increment that sticks at max instead of wrapping (counters up to 32 bits).
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
      return (val >= max) ? max : val + 32'd1;
   endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one control-bundle register stage with valid bit
//
// Purpose: holds one decoded control bundle plus its valid flag.
// Ports:
//   clk        in   clock
//   R          in   synchronous active-low reset
//   flush      in   drop contents, load bubble (beats hold)
//   hold       in   keep contents (this stage or an older one is stalled)
//   bubble_sel in   younger neighbour is frozen: load bubble instead of d_*
//   d_ctrl     in   bundle from the younger stage (or decode for stage 0)
//   d_valid    in   valid flag accompanying d_ctrl
//   q_ctrl     out  registered bundle
//   q_valid    out  registered valid flag
module ctrl_pipe_stage
   import ctrl_pipe_pkg::*;
#(
   parameter int          W      = 16,
   parameter logic [W-1:0] BUBBLE = {W{BUBBLE_BIT_DEFAULT}}
) (
   input  logic         clk,
   input  logic         R,
   input  logic         flush,
   input  logic         hold,
   input  logic         bubble_sel,
   input  logic [W-1:0] d_ctrl,
   input  logic         d_valid,
   output logic [W-1:0] q_ctrl,
   output logic         q_valid
);

   logic [W-1:0] ctrl_q, ctrl_d;
   logic         valid_q, valid_d;

   always_comb begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      if (flush) begin
         ctrl_d  = BUBBLE;
         valid_d = 1'b0;
      end else if (hold) begin
         ctrl_d  = ctrl_q;
         valid_d = valid_q;
      end else if (bubble_sel) begin
         ctrl_d  = BUBBLE;
         valid_d = 1'b0;
      end else begin
         ctrl_d  = d_ctrl;
         valid_d = d_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         ctrl_q  <= BUBBLE;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   assign q_ctrl  = ctrl_q;
   assign q_valid = valid_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - parametrised chain of control-bundle pipeline stages
//
// Purpose: carries decoded control bundles from decode through STAGES
// registers with per-stage stall/flush, automatic bubbles below the deepest
// stalled stage, and saturating stall/bubble debug counters.
// Ports:
//   clk        in   clock
//   R          in   synchronous active-low reset
//   in_ctrl    in   bundle from decode
//   in_valid   in   in_ctrl is a real instruction
//   in_ready   out  stage 0 accepts this cycle (combinational, ~hold[0])
//   stall      in   per-stage stall request
//   flush      in   per-stage flush request
//   clr_cnt    in   synchronous clear of both counters
//   out_ctrl   out  stage k bundle at [k*W +: W]
//   out_valid  out  per-stage valid
//   stall_cnt  out  cycles with hold[0]=1
//   bubble_cnt out  cycles with at least one stall bubble inserted
module ctrl_pipe_chain
   import ctrl_pipe_pkg::*;
#(
   parameter int           W      = 16,
   parameter int           STAGES = 4,
   parameter int           CNT_W  = 16,
   parameter logic [W-1:0] BUBBLE = {W{BUBBLE_BIT_DEFAULT}}
) (
   input  logic                clk,
   input  logic                R,
   input  logic [W-1:0]        in_ctrl,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [STAGES-1:0]   stall,
   input  logic [STAGES-1:0]   flush,
   input  logic                clr_cnt,
   output logic [STAGES*W-1:0] out_ctrl,
   output logic [STAGES-1:0]   out_valid,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    bubble_cnt
);

   localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] bubble_sel;
   logic              bubble_any;
   logic [W-1:0]      ctrl_q [STAGES];
   logic              valid_q [STAGES];

   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // A stage holds if it or any older stage stalls.
      assign hold[k] = |stall[STAGES-1:k];

      if (k == 0) begin : g_head
         assign bubble_sel[k] = 1'b0;
         ctrl_pipe_stage #(.W(W), .BUBBLE(BUBBLE)) u_stage (
            .clk        (clk),
            .R          (R),
            .flush      (flush[k]),
            .hold       (hold[k]),
            .bubble_sel (bubble_sel[k]),
            .d_ctrl     (in_ctrl),
            .d_valid    (in_valid),
            .q_ctrl     (ctrl_q[k]),
            .q_valid    (valid_q[k])
         );
      end else begin : g_body
         // Only the stage just below the deepest stall is moving while its
         // feeder is frozen, so that is where the bubble goes.
         assign bubble_sel[k] = hold[k-1] & ~hold[k];
         ctrl_pipe_stage #(.W(W), .BUBBLE(BUBBLE)) u_stage (
            .clk        (clk),
            .R          (R),
            .flush      (flush[k]),
            .hold       (hold[k]),
            .bubble_sel (bubble_sel[k]),
            .d_ctrl     (ctrl_q[k-1]),
            .d_valid    (valid_q[k-1]),
            .q_ctrl     (ctrl_q[k]),
            .q_valid    (valid_q[k])
         );
      end

      assign out_ctrl[k*W +: W] = ctrl_q[k];
      assign out_valid[k]       = valid_q[k];
   end

   // A flushed stage takes the flush, not the bubble, so it does not count.
   assign bubble_any = |(bubble_sel & ~flush);
   assign in_ready   = ~hold[0];

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d  = '0;
         bubble_cnt_d = '0;
      end else begin
         if (hold[0]) begin
            stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), CNT_MAX));
         end
         if (bubble_any) begin
            bubble_cnt_d = CNT_W'(sat_inc(32'(bubble_cnt_q), CNT_MAX));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - self-checking bench for ctrl_pipe_chain
module tb_ctrl_pipe_chain;

   localparam int           W      = 16;
   localparam int           STAGES = 4;
   localparam int           CNT_W  = 3;
   localparam logic [W-1:0] BUB    = 16'hFFFF;
   localparam int           CMAX   = (1 << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                R;
   logic [W-1:0]        in_ctrl;
   logic                in_valid;
   logic                in_ready;
   logic [STAGES-1:0]   stall;
   logic [STAGES-1:0]   flush;
   logic                clr_cnt;
   logic [STAGES*W-1:0] out_ctrl;
   logic [STAGES-1:0]   out_valid;
   logic [CNT_W-1:0]    stall_cnt;
   logic [CNT_W-1:0]    bubble_cnt;

   ctrl_pipe_chain #(.W(W), .STAGES(STAGES), .CNT_W(CNT_W), .BUBBLE(BUB)) dut (
      .clk        (clk),
      .R          (R),
      .in_ctrl    (in_ctrl),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .stall      (stall),
      .flush      (flush),
      .clr_cnt    (clr_cnt),
      .out_ctrl   (out_ctrl),
      .out_valid  (out_valid),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: pipeline as arrays, hazard handled via the deepest stalled stage.
   logic [W-1:0] m_ctrl  [STAGES];
   logic         m_valid [STAGES];
   int           m_sc;
   int           m_bc;
   logic         accepted;
   logic [W-1:0] seq;

   function automatic int deepest_stall(input logic [STAGES-1:0] s);
      int d = -1;
      for (int j = 0; j < STAGES; j++) if (s[j]) d = j;
      return d;
   endfunction

   task automatic model_edge();
      logic [W-1:0] pc [STAGES];
      logic         pv [STAGES];
      int           d;
      bit           bub;
      d   = deepest_stall(stall);
      bub = 0;
      accepted = (R == 1'b1) && (d < 0);
      if (!R) begin
         for (int k = 0; k < STAGES; k++) begin
            m_ctrl[k] = BUB; m_valid[k] = 1'b0;
         end
         m_sc = 0; m_bc = 0;
         return;
      end
      for (int k = 0; k < STAGES; k++) begin
         pc[k] = m_ctrl[k]; pv[k] = m_valid[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         if (flush[k]) begin
            m_ctrl[k] = BUB; m_valid[k] = 1'b0;
         end else if (k <= d) begin
            // frozen
         end else if (k == 0) begin
            m_ctrl[k] = in_ctrl; m_valid[k] = in_valid;
         end else if (k == d + 1) begin
            m_ctrl[k] = BUB; m_valid[k] = 1'b0; bub = 1;
         end else begin
            m_ctrl[k] = pc[k-1]; m_valid[k] = pv[k-1];
         end
      end
      if (clr_cnt) begin
         m_sc = 0; m_bc = 0;
      end else begin
         if (d >= 0) m_sc = (m_sc + 1 > CMAX) ? CMAX : m_sc + 1;
         if (bub)    m_bc = (m_bc + 1 > CMAX) ? CMAX : m_bc + 1;
      end
   endtask

   // One clock: check in_ready, clock the edge, advance model, check state.
   task automatic tick();
      logic [W-1:0] oc;
      #1;
      check_eq("in_ready", 32'(in_ready), 32'(deepest_stall(stall) < 0));
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < STAGES; k++) begin
         oc = out_ctrl[k*W +: W];
         check_eq($sformatf("ctrl[%0d]", k), 32'(oc), 32'(m_ctrl[k]));
         check_eq($sformatf("valid[%0d]", k), 32'(out_valid[k]), 32'(m_valid[k]));
      end
      check_eq("stall_cnt", 32'(stall_cnt), 32'(m_sc));
      check_eq("bubble_cnt", 32'(bubble_cnt), 32'(m_bc));
   endtask

   task automatic feed_tick();
      in_ctrl = seq;
      tick();
      if (accepted) seq++;
   endtask

   initial begin
      for (int k = 0; k < STAGES; k++) begin
         m_ctrl[k] = BUB; m_valid[k] = 1'b0;
      end
      m_sc = 0; m_bc = 0;
      R = 1'b0; in_ctrl = '0; in_valid = 1'b0;
      stall = '0; flush = '0; clr_cnt = 1'b0;
      seq = 16'h0001;

      // Reset
      repeat (2) tick();
      check_eq("rst_out_valid", 32'(out_valid), 32'h0);
      check_eq("rst_ctrl3", 32'(out_ctrl[3*W +: W]), 32'(BUB));

      // Stream: 0x0001 reaches stage 3 after 4 edges
      R = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         feed_tick();
         if (i == 3) check_eq("latency_stage3", 32'(out_ctrl[3*W +: W]), 32'h0001);
      end

      // Mid-stall on stage 2 for two cycles
      stall = 4'b0100;
      repeat (2) feed_tick();
      check_eq("midstall_stall_cnt", 32'(stall_cnt), 32'd2);
      check_eq("midstall_bubble_cnt", 32'(bubble_cnt), 32'd2);
      stall = '0;
      repeat (5) feed_tick();

      // Flush over stall
      stall = 4'b0010; flush = 4'b0011;
      feed_tick();
      check_eq("flush_over_stall_v", 32'(out_valid[1:0]), 32'h0);
      stall = '0; flush = '0;
      repeat (4) feed_tick();

      // Saturation then clear during continued stall
      clr_cnt = 1'b1; feed_tick(); clr_cnt = 1'b0;
      stall = 4'b1000;
      repeat (10) feed_tick();
      check_eq("sat_stall_cnt", 32'(stall_cnt), 32'd7);
      clr_cnt = 1'b1; feed_tick(); clr_cnt = 1'b0;
      check_eq("clr_wins_stall_cnt", 32'(stall_cnt), 32'd0);

      // Reset while stalled
      R = 1'b0; feed_tick(); R = 1'b1;
      check_eq("rst_mid_valid", 32'(out_valid), 32'h0);
      feed_tick();
      stall = '0;
      repeat (5) feed_tick();

      // Bubble value via flush of stage 2
      flush = 4'b0100; feed_tick(); flush = '0;
      check_eq("flush2_ctrl", 32'(out_ctrl[2*W +: W]), 32'(BUB));
      check_eq("flush2_valid", 32'(out_valid[2]), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         seq      = 16'($urandom);
         for (int k = 0; k < STAGES; k++) begin
            stall[k] = ($urandom_range(0, 9) == 0);
            flush[k] = ($urandom_range(0, 14) == 0);
         end
         clr_cnt = ($urandom_range(0, 29) == 0);
         R       = ($urandom_range(0, 49) != 0);
         feed_tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised pipeline carrier for decoded control bundles. It replaces the fixed per-boundary registers (IF/ID through MEM/WB) with one chain of STAGES registers of W bits each. Each stage has a valid bit, per-stage stall and flush, and automatic bubble insertion below the deepest stalled stage. Saturating stall and bubble counters feed hazard debug. It sits between the Control_Unit/CU_mux output and the datapath stages that consume the per-stage control fields.

## Interface
- W, 16, width of one control bundle
- STAGES, 4, number of pipeline stages (≥2); stage 0 is youngest, STAGES-1 oldest
- CNT_W, 16, width of each performance counter
- BUBBLE, {W{1'b0}}, control value loaded into a stage on reset, flush or bubble

Ports:
- clk  in  1  clock; all state updates on rising edge
- R  in  1  reset, synchronous, active-low
- in_ctrl  in  W  control bundle from decode
- in_valid  in  1  in_ctrl holds a real instruction
- in_ready  out  1  stage 0 accepts this cycle; combinational, equal to ~hold[0]
- stall  in  STAGES  per-stage stall request, active high
- flush  in  STAGES  per-stage flush request, active high
- clr_cnt  in  1  synchronous clear of both counters
- out_ctrl  out  STAGES*W  stage k occupies bits [k*W +: W]
- out_valid  out  STAGES  valid bit per stage
- stall_cnt  out  CNT_W  cycles with hold[0]=1
- bubble_cnt  out  CNT_W  cycles in which at least one stall bubble was inserted

## Operation
- hold[k] = OR of stall[j] for j = k..STAGES-1. A stalled older stage freezes every younger stage.
- Per stage k, at each edge, first matching rule applies:
  1. R=0: valid←0, ctrl←BUBBLE.
  2. flush[k]: valid←0, ctrl←BUBBLE. Flush overrides stall and overrides whatever the stage would have loaded.
  3. hold[k]: keep contents.
  4. k=0: ctrl←in_ctrl, valid←in_valid.
  5. k>0 and hold[k-1]: bubble; valid←0, ctrl←BUBBLE.
  6. Otherwise: ctrl, valid ← stage k-1 pre-edge contents.
- in_ctrl and in_valid are ignored while in_ready=0. The upstream (PC/IF) must hold its instruction.
- A flush of stage k does not affect stage k+1 at the same edge. Stage k+1 takes stage k's pre-edge contents per the rules above.
- Counters:
  - Each counter saturates at 2^CNT_W-1.
  - stall_cnt increments on each edge where hold[0]=1.
  - bubble_cnt increments on each edge where rule 5 fires for any k. It increments by 1 per cycle, regardless of how many stages receive a bubble.
  - Priority: R=0 → 0; clr_cnt → 0, with clr_cnt winning over a simultaneous increment; then increment.
- Reset values:
  - out_valid=0
  - out_ctrl=all BUBBLE
  - stall_cnt=0
  - bubble_cnt=0
  - in_ready follows stall combinationally, even during reset.

## Timing
- Latency with no stall or flush: a bundle presented with in_ready=1 appears at stage k after k+1 rising edges.
- Throughput is one bundle per cycle.
- out_ctrl and out_valid are registered.
- in_ready is the only combinational output; there is no path from in_ctrl to any output.
- Stall applied at cycle t holds at the edge ending cycle t. Release takes effect at the next edge.
- Mid-operation reset clears all stages at one edge, regardless of stall or flush.

## Structure
- Package ctrl_pipe_pkg holds the default BUBBLE constant and the counter saturation helper function.
- Sub-module ctrl_pipe_stage is one register stage with valid. Its inputs are clk, R, flush, hold, bubble_sel, d_ctrl and d_valid. It is instantiated STAGES times in a generate loop.
- The hold prefix-OR and the bubble-detect OR stay in the top level.

## Test plan
- Reset and stream:
  - Stimulus: R=0 for 2 cycles, then R=1; push 0x0001, 0x0002, 0x0003… valid every cycle, STAGES=4.
  - Response: out_valid=0000 and out_ctrl all 0 during reset; 0x0001 reaches stage 3 after 4 edges; the full stream arrives in order with no gaps.
- Mid-stall:
  - Stimulus: stall[2]=1 for 2 cycles with 0x0001..0x0004 in flight.
  - Response: stages 0–2 frozen; stage 3 receives 2 bubbles (valid=0, ctrl=0); in_ready=0 for 2 cycles; stall_cnt=2, bubble_cnt=2; the stream resumes intact.
- Flush over stall:
  - Stimulus: stall[1]=1 and flush[0]=1 and flush[1]=1 in the same cycle.
  - Response: stages 0 and 1 become invalid at that edge; stage 2 gets a bubble; bubble_cnt increments by 1.
- Counter saturation and clear:
  - Stimulus: CNT_W=3; hold stall[3]=1 for 10 cycles, then clr_cnt=1 together with a continued stall.
  - Response: stall_cnt sticks at 7; after the clear it reads 0, not 1.
- Reset mid-stall:
  - Stimulus: while stall[3]=1 with all stages valid, assert R=0 for 1 cycle.
  - Response: all out_valid=0 and both counters 0 after that edge; in_ready=0 while stall[3] stays high.
- Bubble value:
  - Stimulus: BUBBLE=16'hFFFF; flush[2]=1 for 1 cycle.
  - Response: stage 2 out_ctrl=16'hFFFF with out_valid[2]=0.
